if_id_pipe_reg: RTL and testbench

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

---
 rtl/if_id_pkg.sv | 28 ++
 rtl/if_id_sat_cnt.sv | 25 ++
 rtl/if_id_pipe_reg.sv | 96 +++++++++
 tb/tb_if_id_pipe_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// IF/ID pipeline register shared types and defaults.
// Counters are built in only when IF_ID_PERF_EN is defined.
package if_id_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int INS_W_DEF = 32;
  localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTL_RESET = 2'd0,
    CTL_FLUSH = 2'd1,
    CTL_STALL = 2'd2,
    CTL_LOAD  = 2'd3
  } ctl_e;

  // reset > flush > stall > load
  function automatic ctl_e ctl_sel(
    input logic rst,
    input logic flush,
    input logic stall
  );
    if (rst)        return CTL_RESET;
    else if (flush) return CTL_FLUSH;
    else if (stall) return CTL_STALL;
    else            return CTL_LOAD;
  endfunction

endpackage

// File: rtl/if_id_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear beats increment; the count sticks at all-ones.
module if_id_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall, flush and bubble insertion.
// Define IF_ID_PERF_EN to add stall/flush performance counters.
module if_id_pipe_reg
  import if_id_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int INS_W = INS_W_DEF,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [PC_W-1:0]  PCp4_i,
  input  logic [INS_W-1:0] ins_i,
`ifdef IF_ID_PERF_EN
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic [PC_W-1:0]  PCp4_o,
  output logic [INS_W-1:0] ins_o,
  output logic             valid_o
);

  ctl_e w_ctl;

  logic [PC_W-1:0]  r_pcp4;
  logic [INS_W-1:0] r_ins;
  logic             r_valid;

  always_comb begin
    w_ctl = ctl_sel(reset, flush_i, stall_i);
  end

  always_ff @(posedge clk) begin
    unique case (w_ctl)
      CTL_RESET, CTL_FLUSH: begin
        r_pcp4  <= '0;
        r_ins   <= NOP_INS;
        r_valid <= 1'b0;
      end
      CTL_STALL: begin
        r_pcp4  <= r_pcp4;
        r_ins   <= r_ins;
        r_valid <= r_valid;
      end
      CTL_LOAD: begin
        r_pcp4  <= PCp4_i;
        r_ins   <= valid_i ? ins_i : NOP_INS;
        r_valid <= valid_i;
      end
      default: begin
        r_pcp4  <= '0;
        r_ins   <= NOP_INS;
        r_valid <= 1'b0;
      end
    endcase
  end

  assign PCp4_o  = r_pcp4;
  assign ins_o   = r_ins;
  assign valid_o = r_valid;

`ifdef IF_ID_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  // Only cycles that actually delay or kill a real instruction count.
  assign w_stall_inc = stall_i & ~flush_i & r_valid;
  assign w_flush_inc = flush_i & r_valid;

  if_id_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_i),
    .inc   (w_stall_inc),
    .cnt   (stall_cnt_o)
  );

  if_id_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_i),
    .inc   (w_flush_inc),
    .cnt   (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg.
// Counter checks are active when IF_ID_PERF_EN is defined.
module tb_if_id_pipe_reg;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic [31:0] PCp4_i;
  logic [31:0] ins_i;
  logic [31:0] PCp4_o;
  logic [31:0] ins_o;
  logic        valid_o;
`ifdef IF_ID_PERF_EN
  logic             cnt_clr_i;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg #(
    .PC_W    (32),
    .INS_W   (32),
    .NOP_INS (32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .PCp4_i      (PCp4_i),
    .ins_i       (ins_i),
`ifdef IF_ID_PERF_EN
    .cnt_clr_i   (cnt_clr_i),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o),
`endif
    .PCp4_o      (PCp4_o),
    .ins_o       (ins_o),
    .valid_o     (valid_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [31:0] pc,
    input logic [31:0] ins,
    input logic        v
  );
    chk({tag, ".pc"}, PCp4_o, pc);
    chk({tag, ".ins"}, ins_o, ins);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
  endtask

  task automatic chk_cnt(
    input string      tag,
    input logic [3:0] sc,
    input logic [3:0] fc
  );
`ifdef IF_ID_PERF_EN
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt_o}, {28'd0, sc});
    chk({tag, ".flush_cnt"}, {28'd0, flush_cnt_o}, {28'd0, fc});
`else
    if (sc === fc) begin end
`endif
  endtask

  initial begin
    reset   = 1'b1;
    stall_i = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b1;
    PCp4_i  = 32'hDEAD_BEEF;
    ins_i   = 32'hFFFF_FFFF;
`ifdef IF_ID_PERF_EN
    cnt_clr_i = 1'b0;
`endif
    tick();
    tick();
    chk_out("reset", 32'h0, 32'h0, 1'b0);
    chk_cnt("reset", 4'd0, 4'd0);

    // plain load
    reset   = 1'b0;
    stall_i = 1'b0;
    valid_i = 1'b1;
    PCp4_i  = 32'h0040_0004;
    ins_i   = 32'h2008_0005;
    tick();
    chk_out("load", 32'h0040_0004, 32'h2008_0005, 1'b1);

    // three-cycle stall with changing inputs
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCp4_i = 32'h1000_0000 + i;
      ins_i  = 32'hA000_0000 + i;
      valid_i = i[0];
      tick();
      chk_out("stall", 32'h0040_0004, 32'h2008_0005, 1'b1);
    end
    chk_cnt("stall3", 4'd3, 4'd0);

    // release captures the release-cycle inputs
    stall_i = 1'b0;
    valid_i = 1'b1;
    PCp4_i  = 32'h0040_0008;
    ins_i   = 32'h8C09_0000;
    tick();
    chk_out("release", 32'h0040_0008, 32'h8C09_0000, 1'b1);

    // flush and stall together
    stall_i = 1'b1;
    flush_i = 1'b1;
    PCp4_i  = 32'h0040_000C;
    ins_i   = 32'h1234_5678;
    tick();
    chk_out("flush_stall", 32'h0, 32'h0, 1'b0);
    chk_cnt("flush_stall", 4'd3, 4'd1);

    // bubble load
    stall_i = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    PCp4_i  = 32'h0040_0010;
    ins_i   = 32'hFFFF_FFFF;
    tick();
    chk_out("bubble", 32'h0040_0010, 32'h0, 1'b0);
    chk_cnt("bubble", 4'd3, 4'd1);

    // stall on a bubble is not counted
    stall_i = 1'b1;
    tick();
    chk_out("stall_bub", 32'h0040_0010, 32'h0, 1'b0);
    chk_cnt("stall_bub", 4'd3, 4'd1);

    // load, stall, then reset mid-stall
    stall_i = 1'b0;
    valid_i = 1'b1;
    PCp4_i  = 32'h0040_0014;
    ins_i   = 32'h0000_0020;
    tick();
    stall_i = 1'b1;
    tick();
    chk_cnt("pre_rst", 4'd4, 4'd1);
    reset = 1'b1;
    tick();
    chk_out("rst_stall", 32'h0, 32'h0, 1'b0);
    chk_cnt("rst_stall", 4'd0, 4'd0);
    reset   = 1'b0;
    stall_i = 1'b0;
    PCp4_i  = 32'h0040_0018;
    ins_i   = 32'h2010_0007;
    tick();
    chk_out("post_rst", 32'h0040_0018, 32'h2010_0007, 1'b1);

    // saturation over 20 stall cycles
    stall_i = 1'b1;
    repeat (20) tick();
    chk_out("sat_hold", 32'h0040_0018, 32'h2010_0007, 1'b1);
    chk_cnt("sat", 4'd15, 4'd0);
`ifdef IF_ID_PERF_EN
    cnt_clr_i = 1'b1;
    tick();
    chk_cnt("clr", 4'd0, 4'd0);
    cnt_clr_i = 1'b0;
    tick();
    chk_cnt("after_clr", 4'd1, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
